// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Brief    : Shared widths and constants for the music playback datapath.
// Revision : 1.0 - initial release
// ============================================================================
package music_pkg;
    localparam int NOTE_W          = 6;
    localparam int DUR_W           = 7;
    localparam int DEF_NUM_VOICES  = 3;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
endpackage
`default_nettype wire

// File: rtl/voice_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : voice_scheduler_if
// Brief    : Note-event / beat inputs and note-player bank outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface voice_scheduler_if #(
    parameter int NUM_VOICES = music_pkg::DEF_NUM_VOICES,
    parameter int NOTE_W     = music_pkg::NOTE_W,
    parameter int DUR_W      = music_pkg::DUR_W
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic                         play;
    logic                         flush;
    logic                         new_note;
    logic [NOTE_W-1:0]            note;
    logic [DUR_W-1:0]             duration;
    logic                         new_beat;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES-1:0]        voice_active;
    logic [NUM_VOICES-1:0]        voice_load;
    logic                         steal;
    logic [CNT_W-1:0]             active_count;

    modport master (
        output play, flush, new_note, note, duration, new_beat,
        input  voice_note, voice_active, voice_load, steal, active_count
    );

    modport slave (
        input  play, flush, new_note, note, duration, new_beat,
        output voice_note, voice_active, voice_load, steal, active_count
    );
endinterface
`default_nettype wire

// File: rtl/voice_slot.sv
`default_nettype none
// ============================================================================
// Module   : voice_slot
// Brief    : One note-player slot: note register plus beat countdown.
// Revision : 1.0 - initial release
// ============================================================================
module voice_slot
    import music_pkg::*;
#(
    parameter int SLOT_NOTE_W = music_pkg::NOTE_W,
    parameter int SLOT_DUR_W  = music_pkg::DUR_W
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   clear,
    input  wire logic                   load,
    input  wire logic                   beat,
    input  wire logic [SLOT_NOTE_W-1:0] load_note,
    input  wire logic [SLOT_DUR_W-1:0]  load_dur,
    output logic [SLOT_NOTE_W-1:0]      note,
    output logic                        active,
    output logic [SLOT_DUR_W-1:0]       post_rem
);
    logic [SLOT_NOTE_W-1:0] r_note;
    logic [SLOT_DUR_W-1:0]  r_remaining;
    logic                   r_active;

    // Remaining count after this edge's beat; the scheduler scans this value.
    always_comb begin
        post_rem = r_remaining;
        if (beat && (r_remaining != '0)) begin
            post_rem = r_remaining - SLOT_DUR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note      <= SLOT_NOTE_W'(REST_NOTE);
            r_remaining <= '0;
            r_active    <= 1'b0;
        end else if (clear) begin
            r_note      <= SLOT_NOTE_W'(REST_NOTE);
            r_remaining <= '0;
            r_active    <= 1'b0;
        end else if (load) begin
            r_note      <= load_note;
            r_remaining <= load_dur;
            r_active    <= 1'b1;
        end else begin
            r_remaining <= post_rem;
            if (post_rem == '0) begin
                r_note   <= SLOT_NOTE_W'(REST_NOTE);
                r_active <= 1'b0;
            end
        end
    end

    assign note   = r_note;
    assign active = r_active;
endmodule
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : voice_scheduler
// Brief    : Polyphonic voice allocator with beat countdown and voice stealing.
// Revision : 1.0 - initial release
// ============================================================================
module voice_scheduler
    import music_pkg::*;
#(
    parameter int NUM_VOICES = music_pkg::DEF_NUM_VOICES,
    parameter int NOTE_W     = music_pkg::NOTE_W,
    parameter int DUR_W      = music_pkg::DUR_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    voice_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic                         w_beat;
    logic                         w_alloc;
    logic [DUR_W-1:0]             w_post_rem [NUM_VOICES];
    logic [NOTE_W-1:0]            w_note     [NUM_VOICES];
    logic [NUM_VOICES-1:0]        w_active;
    logic [NUM_VOICES-1:0]        w_load;
    logic [NUM_VOICES-1:0]        w_active_next;
    logic                         w_free_found;
    logic [IDX_W-1:0]             w_free_idx;
    logic [IDX_W-1:0]             w_min_idx;
    logic [DUR_W-1:0]             w_min_val;
    logic [IDX_W-1:0]             w_target;
    logic [CNT_W-1:0]             w_count_next;
    logic [NUM_VOICES*NOTE_W-1:0] w_note_flat;

    logic [NUM_VOICES-1:0]        r_voice_load;
    logic                         r_steal;
    logic [CNT_W-1:0]             r_active_count;

    // Flush wins the edge, so events and beats arriving with it are dropped.
    assign w_beat  = bus.play && bus.new_beat && !bus.flush;
    assign w_alloc = bus.play && bus.new_note && !bus.flush &&
                     (bus.note != NOTE_W'(REST_NOTE)) && (bus.duration != '0);

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_min_idx    = '0;
        w_min_val    = w_post_rem[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_free_found && (w_post_rem[i] == '0)) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            // Strict less-than keeps the lowest index on ties.
            if (w_post_rem[i] < w_min_val) begin
                w_min_val = w_post_rem[i];
                w_min_idx = IDX_W'(i);
            end
        end
        w_target = w_free_found ? w_free_idx : w_min_idx;
        w_load   = '0;
        w_load[w_target] = w_alloc;
    end

    always_comb begin
        w_active_next = '0;
        w_count_next  = '0;
        w_note_flat   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_active_next[i] = !bus.flush && (w_load[i] || (w_post_rem[i] != '0));
            w_count_next     = w_count_next + CNT_W'(w_active_next[i]);
            w_note_flat[i*NOTE_W +: NOTE_W] = w_note[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
            voice_slot #(
                .SLOT_NOTE_W (NOTE_W),
                .SLOT_DUR_W  (DUR_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (bus.flush),
                .load      (w_load[g]),
                .beat      (w_beat),
                .load_note (bus.note),
                .load_dur  (bus.duration),
                .note      (w_note[g]),
                .active    (w_active[g]),
                .post_rem  (w_post_rem[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_voice_load   <= '0;
            r_steal        <= 1'b0;
            r_active_count <= '0;
        end else begin
            r_voice_load   <= w_load;
            r_steal        <= w_alloc && !w_free_found;
            r_active_count <= w_count_next;
        end
    end

    assign bus.voice_note   = w_note_flat;
    assign bus.voice_active = w_active;
    assign bus.voice_load   = r_voice_load;
    assign bus.steal        = r_steal;
    assign bus.active_count = r_active_count;
endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_scheduler
// Brief    : Directed self-checking bench for voice_scheduler (3 voices).
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_scheduler;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    voice_scheduler_if #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(7)) vif ();

    voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [5:0] n, input logic [6:0] d);
        vif.note     = n;
        vif.duration = d;
        vif.new_note = 1'b1;
        tick();
        vif.new_note = 1'b0;
    endtask

    task automatic beat();
        vif.new_beat = 1'b1;
        tick();
        vif.new_beat = 1'b0;
    endtask

    task automatic flush();
        vif.flush = 1'b1;
        tick();
        vif.flush = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({vif.voice_note, vif.voice_active, vif.voice_load, vif.steal, vif.active_count} !== '0) begin
            n_fail++;
            $display("FAIL reset: outputs=%h required 0",
                     {vif.voice_note, vif.voice_active, vif.voice_load, vif.steal, vif.active_count});
        end
    endtask

    task automatic test_fill();
        ev(6'd10, 7'd4);
        n_tests++;
        if (vif.voice_load !== 3'b001) begin n_fail++; $display("FAIL fill_load0: got %b required 001", vif.voice_load); end
        ev(6'd12, 7'd2);
        n_tests++;
        if (vif.voice_load !== 3'b010) begin n_fail++; $display("FAIL fill_load1: got %b required 010", vif.voice_load); end
        ev(6'd15, 7'd3);
        n_tests++;
        if (vif.voice_load !== 3'b100) begin n_fail++; $display("FAIL fill_load2: got %b required 100", vif.voice_load); end
        n_tests++;
        if (vif.voice_note !== {6'd15, 6'd12, 6'd10}) begin n_fail++; $display("FAIL fill_notes: got %h required %h", vif.voice_note, {6'd15, 6'd12, 6'd10}); end
        n_tests++;
        if (vif.active_count !== 2'd3 || vif.voice_active !== 3'b111) begin
            n_fail++; $display("FAIL fill_count: got %0d/%b required 3/111", vif.active_count, vif.voice_active);
        end
    endtask

    task automatic test_expiry();
        beat();
        beat();
        n_tests++;
        if (vif.voice_active !== 3'b101 || vif.active_count !== 2'd2) begin
            n_fail++; $display("FAIL expiry_active: got %b/%0d required 101/2", vif.voice_active, vif.active_count);
        end
        n_tests++;
        if (vif.voice_note !== {6'd15, 6'd0, 6'd10}) begin n_fail++; $display("FAIL expiry_notes: got %h required %h", vif.voice_note, {6'd15, 6'd0, 6'd10}); end
        // remaining {2,0,1}: one more beat retires voice2 only
        beat();
        n_tests++;
        if (vif.voice_active !== 3'b001 || vif.active_count !== 2'd1) begin
            n_fail++; $display("FAIL expiry_rem: got %b/%0d required 001/1", vif.voice_active, vif.active_count);
        end
    endtask

    task automatic test_steal();
        flush();
        ev(6'd10, 7'd3);
        ev(6'd12, 7'd1);
        ev(6'd15, 7'd2);
        ev(6'd20, 7'd5);
        n_tests++;
        if (vif.voice_load !== 3'b010 || vif.steal !== 1'b1) begin
            n_fail++; $display("FAIL steal_pulse: got load=%b steal=%b required 010/1", vif.voice_load, vif.steal);
        end
        n_tests++;
        if (vif.voice_note !== {6'd15, 6'd20, 6'd10} || vif.active_count !== 2'd3) begin
            n_fail++; $display("FAIL steal_state: got %h/%0d required %h/3", vif.voice_note, vif.active_count, {6'd15, 6'd20, 6'd10});
        end
        tick();
        n_tests++;
        if (vif.steal !== 1'b0 || vif.voice_load !== 3'b000) begin
            n_fail++; $display("FAIL steal_oneshot: got steal=%b load=%b required 0/000", vif.steal, vif.voice_load);
        end
        flush();
        ev(6'd1, 7'd2);
        ev(6'd2, 7'd2);
        ev(6'd3, 7'd2);
        ev(6'd4, 7'd3);
        n_tests++;
        if (vif.voice_load !== 3'b001 || vif.steal !== 1'b1 || vif.voice_note !== {6'd3, 6'd2, 6'd4}) begin
            n_fail++; $display("FAIL steal_tie: got load=%b steal=%b notes=%h required 001/1/%h",
                               vif.voice_load, vif.steal, vif.voice_note, {6'd3, 6'd2, 6'd4});
        end
    endtask

    task automatic test_rest();
        ev(6'd0, 7'd8);
        n_tests++;
        if (vif.voice_load !== 3'b000 || vif.steal !== 1'b0 || vif.voice_note !== {6'd3, 6'd2, 6'd4}) begin
            n_fail++; $display("FAIL rest_note: got load=%b steal=%b notes=%h required 000/0/%h",
                               vif.voice_load, vif.steal, vif.voice_note, {6'd3, 6'd2, 6'd4});
        end
        ev(6'd9, 7'd0);
        n_tests++;
        if (vif.voice_load !== 3'b000 || vif.steal !== 1'b0 || vif.active_count !== 2'd3 ||
            vif.voice_note !== {6'd3, 6'd2, 6'd4}) begin
            n_fail++; $display("FAIL rest_zero_dur: got load=%b steal=%b cnt=%0d notes=%h required 000/0/3/%h",
                               vif.voice_load, vif.steal, vif.active_count, vif.voice_note, {6'd3, 6'd2, 6'd4});
        end
    endtask

    task automatic test_simultaneous();
        flush();
        ev(6'd10, 7'd1);
        ev(6'd12, 7'd4);
        ev(6'd15, 7'd4);
        vif.new_beat = 1'b1;
        ev(6'd30, 7'd6);
        vif.new_beat = 1'b0;
        n_tests++;
        if (vif.voice_load !== 3'b001 || vif.steal !== 1'b0 || vif.voice_note !== {6'd15, 6'd12, 6'd30}) begin
            n_fail++; $display("FAIL simul_load: got load=%b steal=%b notes=%h required 001/0/%h",
                               vif.voice_load, vif.steal, vif.voice_note, {6'd15, 6'd12, 6'd30});
        end
        // remaining {6,3,3}: three beats leave only voice0 sounding
        for (int i = 0; i < 3; i++) beat();
        n_tests++;
        if (vif.voice_active !== 3'b001 || vif.active_count !== 2'd1 || vif.voice_note !== {6'd0, 6'd0, 6'd30}) begin
            n_fail++; $display("FAIL simul_reload_dur: got %b/%0d/%h required 001/1/%h",
                               vif.voice_active, vif.active_count, vif.voice_note, {6'd0, 6'd0, 6'd30});
        end
    endtask

    task automatic test_freeze_flush_reset();
        vif.play = 1'b0;
        for (int i = 0; i < 3; i++) beat();
        ev(6'd5, 7'd5);
        n_tests++;
        if (vif.voice_active !== 3'b001 || vif.voice_load !== 3'b000) begin
            n_fail++; $display("FAIL freeze_hold: got active=%b load=%b required 001/000", vif.voice_active, vif.voice_load);
        end
        vif.play = 1'b1;
        beat();
        beat();
        n_tests++;
        if (vif.voice_active !== 3'b001) begin n_fail++; $display("FAIL freeze_rem: got %b required 001", vif.voice_active); end
        beat();
        n_tests++;
        if (vif.voice_active !== 3'b000 || vif.active_count !== 2'd0) begin
            n_fail++; $display("FAIL freeze_expire: got %b/%0d required 000/0", vif.voice_active, vif.active_count);
        end
        ev(6'd10, 7'd5);
        ev(6'd12, 7'd5);
        vif.flush = 1'b1;
        ev(6'd30, 7'd6);
        vif.flush = 1'b0;
        n_tests++;
        if (vif.voice_active !== 3'b000 || vif.voice_load !== 3'b000 || vif.active_count !== 2'd0 ||
            vif.voice_note !== '0) begin
            n_fail++; $display("FAIL flush: got active=%b load=%b cnt=%0d notes=%h required all 0",
                               vif.voice_active, vif.voice_load, vif.active_count, vif.voice_note);
        end
        ev(6'd10, 7'd5);
        ev(6'd12, 7'd5);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vif.voice_note, vif.voice_active, vif.voice_load, vif.steal, vif.active_count} !== '0) begin
            n_fail++; $display("FAIL async_reset: outputs=%h required 0",
                               {vif.voice_note, vif.voice_active, vif.voice_load, vif.steal, vif.active_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        vif.play     = 1'b0;
        vif.flush    = 1'b0;
        vif.new_note = 1'b0;
        vif.note     = '0;
        vif.duration = '0;
        vif.new_beat = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        vif.play = 1'b1;
        tick();
        test_reset();
        test_fill();
        test_expiry();
        test_steal();
        test_rest();
        test_simultaneous();
        test_freeze_flush_reset();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
